call_stack: RTL and testbench

// Hardware return-address stack that sits beside pc. A call pushes pc's

---
 rtl/call_stack.sv | 116 +++++++++++
 tb/tb_call_stack.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/call_stack.sv
// Hardware return-address stack: circular buffer of DEPTH return addresses with
// registered pop output and sticky overflow/underflow flags for the trap logic.
module call_stack #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushaddr,
   input  logic                     pop,
   output logic [WIDTH-1:0]         popaddr,
   output logic                     popvalid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]    ptr_q, ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] popaddr_q, popaddr_d;
   logic             popvalid_q, popvalid_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             empty_c, full_c;
   logic             wr_en;
   logic [AW-1:0]    wr_ptr;

   assign empty_c = (count_q == '0);
   assign full_c  = (count_q == FULL_CNT);

   always_comb begin
      ptr_d      = ptr_q;
      count_d    = count_q;
      popaddr_d  = popaddr_q;
      popvalid_d = 1'b0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      wr_en      = 1'b0;
      wr_ptr     = ptr_q + AW'(1);

      if (push && pop && !empty_c) begin
         // Replace-top: pop reads the pre-push top while the push overwrites it.
         popaddr_d  = mem_q[ptr_q];
         popvalid_d = 1'b1;
         wr_en      = 1'b1;
         wr_ptr     = ptr_q;
      end else if (push) begin
         wr_en = 1'b1;
         ptr_d = ptr_q + AW'(1);
         if (!full_c) begin
            count_d = count_q + (AW+1)'(1);
         end
      end else if (pop && !empty_c) begin
         popaddr_d  = mem_q[ptr_q];
         popvalid_d = 1'b1;
         ptr_d      = ptr_q - AW'(1);
         count_d    = count_q - (AW+1)'(1);
      end

      // Clear first so an error event in the same cycle wins.
      if (clr_err) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (pop && empty_c) begin
         unf_d = 1'b1;
      end
      if (push && !pop && full_c) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q      <= '0;
         count_q    <= '0;
         popaddr_q  <= '0;
         popvalid_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         popaddr_q  <= popaddr_d;
         popvalid_q <= popvalid_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Entry storage carries no reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= pushaddr;
      end
   end

   assign popaddr   = popaddr_q;
   assign popvalid  = popvalid_q;
   assign count     = count_q;
   assign empty     = empty_c;
   assign full      = full_c;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack: expected pop addresses are queued at issue
// time and a negedge monitor checks each popvalid pulse against the queue.
module tb_call_stack;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned WIDTH = 64;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   push;
   logic [WIDTH-1:0]       pushaddr;
   logic                   pop;
   logic [WIDTH-1:0]       popaddr;
   logic                   popvalid;
   logic [$clog2(DEPTH):0] count;
   logic                   empty;
   logic                   full;
   logic                   overflow;
   logic                   underflow;
   logic                   clr_err;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [WIDTH-1:0] exp_q [$];

   call_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .push(push), .pushaddr(pushaddr), .pop(pop),
      .popaddr(popaddr), .popvalid(popvalid), .count(count), .empty(empty),
      .full(full), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   // Monitor: every popvalid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && popvalid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected got=%h want=no_pop", popaddr);
         end else begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            if (popaddr !== e) begin
               bad++;
               $display("FAIL popaddr got=%h want=%h", popaddr, e);
            end
         end
      end
   end

   task automatic step(input logic p, input logic [WIDTH-1:0] a, input logic q, input logic c);
      push = p; pushaddr = a; pop = q; clr_err = c;
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
   endtask

   task automatic do_push(input logic [WIDTH-1:0] a);
      step(1'b1, a, 1'b0, 1'b0);
   endtask

   task automatic do_pop(input logic [WIDTH-1:0] want);
      exp_q.push_back(want);
      step(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; push = 1'b0; pushaddr = '0; pop = 1'b0; clr_err = 1'b0;
      @(negedge clk);
      // Test 1: reset state
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_popvalid", popvalid, 0);
      chk("rst_popaddr", popaddr, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Test 2: basic LIFO order
      do_push('h100); do_push('h200); do_push('h300);
      chk("t2_count3", count, 3);
      do_pop('h300); do_pop('h200); do_pop('h100);
      chk("t2_empty", empty, 1);

      // Test 3: overflow wraps over the oldest entry, then underflow
      for (int i = 1; i <= 16; i++) do_push(64'(i * 'h10));
      chk("t3_count16", count, 16);
      chk("t3_full16", full, 1);
      chk("t3_no_ovf_yet", overflow, 0);
      do_push('h110);
      chk("t3_ovf", overflow, 1);
      chk("t3_count_sat", count, 16);
      chk("t3_full", full, 1);
      for (int k = 17; k >= 2; k--) do_pop(64'(k * 'h10));
      chk("t3_empty", empty, 1);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t3_unf", underflow, 1);
      chk("t3_unf_popvalid", popvalid, 0);
      chk("t3_unf_popaddr_hold", popaddr, 'h20);
      // Clear racing a new underflow: the new event wins
      step(1'b0, '0, 1'b1, 1'b1);
      chk("clr_race_unf", underflow, 1);
      chk("clr_race_ovf", overflow, 0);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clr_unf", underflow, 0);

      // Test 4: replace-top
      do_push('h40); do_push('h50);
      exp_q.push_back('h50);
      step(1'b1, 'h60, 1'b1, 1'b0);
      chk("t4_count", count, 2);
      chk("t4_no_ovf", overflow, 0);
      do_pop('h60);
      do_pop('h40);
      chk("t4_empty", empty, 1);

      // Test 5: push+pop on empty
      step(1'b1, 'h80, 1'b1, 1'b0);
      chk("t5_unf", underflow, 1);
      chk("t5_popvalid", popvalid, 0);
      chk("t5_count", count, 1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("t5_clr_unf", underflow, 0);
      chk("t5_clr_ovf", overflow, 0);
      do_pop('h80);

      // Test 6: async reset in the middle of a pop cycle
      do_push('h60);
      pop = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("t6_count", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_full", full, 0);
      chk("t6_popvalid", popvalid, 0);
      chk("t6_popaddr", popaddr, 0);
      chk("t6_ovf", overflow, 0);
      chk("t6_unf", underflow, 0);
      pop = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      step(1'b0, '0, 1'b1, 1'b0);
      chk("t6_unf_after", underflow, 1);
      chk("t6_popvalid_after", popvalid, 0);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
